// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables, rotation schedule,
// scheduler state type and 28-bit half rotations.
package des_pkg;

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned CD_W     = 56;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned IDX_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } key_state_t;

  // FIPS 46 bit numbers, bit 1 is the MSB of the source word
  localparam int unsigned PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Entry i holds the rotation for round i+1
  localparam logic [1:0] SHIFTS [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] p;
    p = '0;
    for (int i = 0; i < 56; i++) begin
      p[6'(55 - i)] = key[6'(64 - PC1[6'(i)])];
    end
    return p;
  endfunction

  function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
    return 28'((x << n) | (x >> (5'd28 - {3'b000, n})));
  endfunction

  function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                               input logic [1:0] n);
    return 28'((x >> n) | (x << (5'd28 - {3'b000, n})));
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: 56-bit {C,D} to a 48-bit round subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [CD_W-1:0]     cd,
  output logic [SUBKEY_W-1:0] k
);

  always_comb begin
    k = '0;
    for (int i = 0; i < 48; i++) begin
      k[6'(47 - i)] = cd[6'(56 - PC2[6'(i)])];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES subkey generator: one subkey per handshake, forward order
// with left rotations or reverse order with right rotations.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                decrypt,
  input  logic [KEY_W-1:0]    key_in,
  input  logic                subkey_ready,
  output logic [SUBKEY_W-1:0] subkey,
  output logic                subkey_valid,
  output logic [IDX_W-1:0]    round_idx,
  output logic                busy,
  output logic                done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);

  key_state_t        state;
  logic              dec_q;
  logic [HALF_W-1:0] c_q;
  logic [HALF_W-1:0] d_q;
  logic [CD_W-1:0]   pc1_key_c;
  logic [1:0]        shift_c;

  assign pc1_key_c = pc1(key_in);

  // Decrypt walks the table backwards: C16D16 equals C0D0, then undo S[16..2]
  always_comb begin
    shift_c = 2'd0;
    if (dec_q) shift_c = SHIFTS[4'(4'd15 - round_idx)];
    else       shift_c = SHIFTS[4'(round_idx + 4'd1)];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      dec_q        <= 1'b0;
      c_q          <= '0;
      d_q          <= '0;
      round_idx    <= '0;
      subkey_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dec_q        <= decrypt;
            round_idx    <= '0;
            c_q          <= decrypt ? pc1_key_c[55:28] : rotl28(pc1_key_c[55:28], 2'd1);
            d_q          <= decrypt ? pc1_key_c[27:0]  : rotl28(pc1_key_c[27:0], 2'd1);
            subkey_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= GEN;
          end
        end
        GEN: begin
          if (subkey_ready) begin
            if (round_idx == LAST_IDX) begin
              subkey_valid <= 1'b0;
              done         <= 1'b1;
              state        <= DONE;
            end else begin
              round_idx <= round_idx + 4'd1;
              c_q       <= dec_q ? rotr28(c_q, shift_c) : rotl28(c_q, shift_c);
              d_q       <= dec_q ? rotr28(d_q, shift_c) : rotl28(d_q, shift_c);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          subkey_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  des_pc2 u_pc2 (
    .cd ({c_q, d_q}),
    .k  (subkey)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: directed known-answer runs plus random keys
// and random backpressure against a closed-form subkey model.
module tb_des_key_schedule;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic        decrypt;
  logic [63:0] key_in;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [47:0] exp_k [16];
  logic [47:0] got   [16];

  localparam logic [63:0] KAT = 64'h133457799BBCDFF1;

  int pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int s_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .decrypt      (decrypt),
    .key_in       (key_in),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Subkey r taken straight from C0D0 rotated by the cumulative shift total
  function automatic void model(input logic [63:0] key);
    logic cd0 [56];
    logic cd  [56];
    logic [47:0] k;
    int tot;
    tot = 0;
    for (int q = 0; q < 56; q++) cd0[q] = key[6'(64 - pc1_t[q])];
    for (int r = 0; r < 16; r++) begin
      tot += s_t[r];
      for (int j = 0; j < 28; j++) begin
        cd[j]      = cd0[(j + tot) % 28];
        cd[28 + j] = cd0[28 + ((j + tot) % 28)];
      end
      k = '0;
      for (int p = 0; p < 48; p++) k[6'(47 - p)] = cd[pc2_t[p] - 1];
      exp_k[r] = k;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full schedule; stall_at/stall_len inject a fixed stall, rnd a random one
  task automatic run(input logic [63:0] key, input logic dec, input int stall_at,
                     input int stall_len, input int poke_at, input bit rnd);
    int n;
    int stall;
    int budget;
    bit rdy;
    model(key);
    key_in = key;
    decrypt = dec;
    start = 1'b1;
    subkey_ready = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    stall = stall_len;
    budget = 0;
    while (n < 16 && budget < 400) begin
      budget++;
      check("valid", 64'(subkey_valid), 64'(1));
      check("busy", 64'(busy), 64'(1));
      check("idx", 64'(round_idx), 64'(n));
      check("subkey", 64'(subkey), 64'(exp_k[dec ? 15 - n : n]));
      if (n == poke_at) begin
        start = 1'b1;
        key_in = ~key;
        decrypt = ~dec;
      end else begin
        start = 1'b0;
      end
      if (rnd) rdy = ($urandom_range(0, 3) != 0);
      else     rdy = !(n == stall_at && stall > 0);
      if (!rnd && !rdy) stall--;
      subkey_ready = rdy;
      if (rdy) begin
        got[n] = subkey;
        n++;
      end
      step();
    end
    start = 1'b0;
    subkey_ready = 1'b1;
    check("handshakes", 64'(n), 64'(16));
    check("done_pulse", 64'(done), 64'(1));
    check("done_valid", 64'(subkey_valid), 64'(0));
    check("done_busy", 64'(busy), 64'(1));
    start = 1'b1;
    step();
    start = 1'b0;
    check("idle_done", 64'(done), 64'(0));
    check("idle_busy", 64'(busy), 64'(0));
    check("idle_valid", 64'(subkey_valid), 64'(0));
  endtask

  initial begin
    clk = 1'b0;
    n_rst = 1'b0;
    start = 1'b0;
    decrypt = 1'b0;
    key_in = '0;
    subkey_ready = 1'b0;
    #12;
    check("rst_subkey", 64'(subkey), 64'(0));
    check("rst_valid", 64'(subkey_valid), 64'(0));
    check("rst_idx", 64'(round_idx), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    @(negedge clk);
    n_rst = 1'b1;
    step();
    check("post_rst_valid", 64'(subkey_valid), 64'(0));

    // Known-answer encrypt and decrypt
    run(KAT, 1'b0, -1, 0, -1, 1'b0);
    check("enc_k1", 64'(got[0]), 64'(48'h1B02EFFC7072));
    check("enc_k2", 64'(got[1]), 64'(48'h79AED9DBC9E5));
    check("enc_k16", 64'(got[15]), 64'(48'hCB3D8B0E17F5));
    run(KAT, 1'b1, -1, 0, -1, 1'b0);
    check("dec_i0", 64'(got[0]), 64'(48'hCB3D8B0E17F5));
    check("dec_i14", 64'(got[14]), 64'(48'h79AED9DBC9E5));
    check("dec_i15", 64'(got[15]), 64'(48'h1B02EFFC7072));

    // Backpressure, ignored start mid-run and on the final handshake
    run(KAT, 1'b0, 3, 5, -1, 1'b0);
    run(KAT, 1'b0, -1, 0, 7, 1'b0);
    run(KAT, 1'b1, -1, 0, 15, 1'b0);

    // Parity bits must not matter
    run(KAT ^ 64'h0101010101010101, 1'b0, -1, 0, -1, 1'b0);
    check("par_k1", 64'(got[0]), 64'(48'h1B02EFFC7072));
    check("par_k16", 64'(got[15]), 64'(48'hCB3D8B0E17F5));

    // Asynchronous reset in the middle of a schedule
    key_in = KAT;
    decrypt = 1'b0;
    subkey_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("mid_idx", 64'(round_idx), 64'(9));
    #3 n_rst = 1'b0;
    #1;
    check("arst_subkey", 64'(subkey), 64'(0));
    check("arst_valid", 64'(subkey_valid), 64'(0));
    check("arst_idx", 64'(round_idx), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    #2 n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("arst_quiet", 64'({subkey_valid, busy, done}), 64'(0));
    end
    run(KAT, 1'b1, -1, 0, -1, 1'b0);

    // Random keys, direction and backpressure
    for (int r = 0; r < 6; r++) begin
      run({$urandom, $urandom}, 1'($urandom_range(0, 1)), -1, 0,
          int'($urandom_range(0, 20)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
